// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Optional watchdog on the WAIT state is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_done,
  output logic                       timeout_err
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t            state_reg;
  logic [ID_W-1:0]   last_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic [DATA_W-1:0] slot [NUM_REQ];
  logic              pick_valid;
  logic [ID_W-1:0]   pick_id;
  logic              wd_expire;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    assign slot[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Scan from the farthest offset down so the nearest requester after last_reg wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last_reg) + k) % NUM_REQ]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'((int'(last_reg) + k) % NUM_REQ);
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_reg;

  // A real completion on the expiry edge wins, so the flag is not raised.
  assign wd_expire = (wd_cnt_reg == WD_LAST) && !tx_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_reg  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_reg != WAIT) begin
        wd_cnt_reg <= '0;
      end else begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
        if (wd_expire) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      last_reg    <= LAST_INIT;
      gap_cnt_reg <= '0;
      ack         <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            grant_id  <= pick_id;
            tx_data   <= slot[pick_id];
            tx_start  <= 1'b1;
            busy      <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: state_reg <= WAIT;
        WAIT: begin
          if (tx_done || wd_expire) begin
            ack         <= NUM_REQ'(1) << grant_id;
            last_reg    <= grant_id;
            gap_cnt_reg <= '0;
            if (GAP_CYCLES > 0) begin
              state_reg <= GAP;
            end else begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, hand sequences (gap, reset, watchdog) and a
// randomized run against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req, ack, g_req, g_ack;
  logic [31:0] req_data, g_data;
  logic [1:0]  grant_id, g_grant_id;
  logic        busy, tx_start, tx_done, timeout_err;
  logic        g_busy, g_tx_start, g_done, g_timeout_err;
  logic [7:0]  tx_data, g_tx_data;

  int   n_checks = 0;
  int   n_err    = 0;
  int   m_last   = 3;
  logic m_terr   = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(64)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .ack(ack),
    .grant_id(grant_id), .busy(busy), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .timeout_err(timeout_err)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(3), .TIMEOUT_CYCLES(64)) u_gap (
    .clk(clk), .reset_n(reset_n), .req(g_req), .req_data(g_data), .ack(g_ack),
    .grant_id(g_grant_id), .busy(g_busy), .tx_start(g_tx_start), .tx_data(g_tx_data),
    .tx_done(g_done), .timeout_err(g_timeout_err)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          dly;
    int          exp_id;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [9];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  // Round-robin rule: first asserted index after the last granted one, wrapping.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // One complete frame with an idle arbiter at entry; completion dly cycles after start.
  task automatic run_frame(input string tag, input logic [3:0] r, input logic [31:0] d,
                           input int dly, input int exp_id, input logic [7:0] exp_data);
    req = r;
    req_data = d;
    tick;
    chk(tag, "tx_start", 32'(tx_start), 32'(1));
    chk(tag, "grant_id", 32'(grant_id), 32'(exp_id));
    chk(tag, "tx_data", 32'(tx_data), 32'(exp_data));
    chk(tag, "busy", 32'(busy), 32'(1));
    req_data = ~d;
    tick;
    chk(tag, "start_len", 32'(tx_start), 32'(0));
    for (int i = 2; i < dly; i++) begin
      tick;
      chk(tag, "ack_early", 32'(ack), 32'(0));
    end
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk(tag, "ack", 32'(ack), 32'(4'b1 << exp_id));
    chk(tag, "busy_end", 32'(busy), 32'(0));
    chk(tag, "tx_data_hold", 32'(tx_data), 32'(exp_data));
    chk(tag, "timeout_err", 32'(timeout_err), 32'(m_terr));
    m_last = exp_id;
    req = 4'b0;
    tick;
    chk(tag, "ack_len", 32'(ack), 32'(0));
    chk(tag, "idle_start", 32'(tx_start), 32'(0));
  endtask

  task automatic rand_test(input int n);
    int         win, dly, b, k;
    logic [7:0] exp_d;
    for (int f = 0; f < n; f++) begin
      if (req == 4'b0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) begin
          tx_done = 1'($urandom_range(0, 1));
          tick;
          tx_done = 1'b0;
          chk("rand", "idle_busy", 32'(busy), 32'(0));
          chk("rand", "idle_ack", 32'(ack), 32'(0));
        end
      end
      req_data = $urandom;
      req = req | 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) req[$urandom_range(0, 3)] = 1'b0;
      if (req == 4'b0) req = 4'b1 << $urandom_range(0, 3);
      win = rr_pick(req, m_last);
      exp_d = req_data[win*8 +: 8];
      tick;
      chk("rand", "tx_start", 32'(tx_start), 32'(1));
      chk("rand", "grant_id", 32'(grant_id), 32'(win));
      chk("rand", "tx_data", 32'(tx_data), 32'(exp_d));
      chk("rand", "ack_at_grant", 32'(ack), 32'(0));
      chk("rand", "timeout_err", 32'(timeout_err), 32'(m_terr));
      req_data = $urandom;
      if ($urandom_range(0, 2) == 0) req[win] = 1'b0;
      tx_done = ($urandom_range(0, 3) == 0);
      tick;
      tx_done = 1'b0;
      chk("rand", "start_len", 32'(tx_start), 32'(0));
      chk("rand", "ack_issue", 32'(ack), 32'(0));
      dly = $urandom_range(0, 10);
      for (int i = 0; i < dly; i++) begin
        b = $urandom_range(0, 3);
        if (b != win && $urandom_range(0, 3) == 0) req[b] = 1'b1;
        req_data = $urandom;
        tick;
        chk("rand", "ack_wait", 32'(ack), 32'(0));
        chk("rand", "hold_data", 32'(tx_data), 32'(exp_d));
        chk("rand", "hold_id", 32'(grant_id), 32'(win));
      end
      tx_done = 1'b1;
      b = $urandom_range(0, 3);
      if (b != win) req[b] = 1'b1;
      tick;
      tx_done = 1'b0;
      chk("rand", "ack", 32'(ack), 32'(4'b1 << win));
      chk("rand", "busy_end", 32'(busy), 32'(0));
      m_last = win;
      req[win] = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{4'b1111, 32'h13121110, 10, 0, 8'h10};
    vecs[1] = '{4'b1111, 32'h13121110,  2, 1, 8'h11};
    vecs[2] = '{4'b1111, 32'h13121110,  5, 2, 8'h12};
    vecs[3] = '{4'b1111, 32'h13121110,  3, 3, 8'h13};
    vecs[4] = '{4'b1111, 32'h13121110,  7, 0, 8'h10};
    vecs[5] = '{4'b0100, 32'h00A50000, 10, 2, 8'hA5};
    vecs[6] = '{4'b1000, 32'h77000000,  4, 3, 8'h77};
    vecs[7] = '{4'b1001, 32'h880000E1,  6, 0, 8'hE1};
    vecs[8] = '{4'b1001, 32'h880000E1,  2, 3, 8'h88};

    reset_n = 1'b0;
    req = 4'b0; req_data = 32'h0; tx_done = 1'b0;
    g_req = 4'b0; g_data = 32'h0; g_done = 1'b0;
    tick;
    tick;
    chk("reset", "ack", 32'(ack), 32'(0));
    chk("reset", "grant_id", 32'(grant_id), 32'(0));
    chk("reset", "busy", 32'(busy), 32'(0));
    chk("reset", "tx_start", 32'(tx_start), 32'(0));
    chk("reset", "tx_data", 32'(tx_data), 32'(0));
    chk("reset", "timeout_err", 32'(timeout_err), 32'(0));
    chk("reset", "g_busy", 32'(g_busy), 32'(0));
    chk("reset", "g_timeout_err", 32'(g_timeout_err), 32'(0));
    reset_n = 1'b1;
    tick;
    chk("reset", "idle_after", 32'(busy), 32'(0));

    // Inter-frame gap of 3 cycles on the second instance.
    g_req = 4'b0011;
    g_data = 32'h0000B2A1;
    tick;
    chk("gap", "tx_start0", 32'(g_tx_start), 32'(1));
    chk("gap", "grant0", 32'(g_grant_id), 32'(0));
    chk("gap", "tx_data0", 32'(g_tx_data), 32'(8'hA1));
    tick;
    tick;
    g_done = 1'b1;
    tick;
    g_done = 1'b0;
    chk("gap", "ack0", 32'(g_ack), 32'(4'b0001));
    chk("gap", "busy_in_gap", 32'(g_busy), 32'(1));
    g_req = 4'b0010;
    for (int i = 1; i <= 3; i++) begin
      tick;
      chk("gap", "no_start", 32'(g_tx_start), 32'(0));
      chk("gap", "busy_step", 32'(g_busy), 32'((i < 3) ? 1 : 0));
    end
    tick;
    chk("gap", "tx_start1", 32'(g_tx_start), 32'(1));
    chk("gap", "grant1", 32'(g_grant_id), 32'(1));
    chk("gap", "tx_data1", 32'(g_tx_data), 32'(8'hB2));
    tick;
    g_done = 1'b1;
    tick;
    g_done = 1'b0;
    chk("gap", "ack1", 32'(g_ack), 32'(4'b0010));
    g_req = 4'b0;
    tick;
    tick;
    tick;
    chk("gap", "idle_end", 32'(g_busy), 32'(0));

    for (int i = 0; i < 9; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].req, vecs[i].data, vecs[i].dly,
                vecs[i].exp_id, vecs[i].exp_data);
    end

`ifdef UART_ARB_TIMEOUT_EN
    req = 4'b0100;
    req_data = 32'h00C30000;
    tick;
    chk("timeout", "tx_start", 32'(tx_start), 32'(1));
    chk("timeout", "grant_id", 32'(grant_id), 32'(2));
    for (int i = 0; i < 64; i++) begin
      tick;
      chk("timeout", "ack_early", 32'(ack), 32'(0));
    end
    chk("timeout", "err_early", 32'(timeout_err), 32'(0));
    tick;
    chk("timeout", "ack", 32'(ack), 32'(4'b0100));
    chk("timeout", "err", 32'(timeout_err), 32'(1));
    chk("timeout", "busy_end", 32'(busy), 32'(0));
    m_last = 2;
    m_terr = 1'b1;
    req = 4'b0;
    tick;
    run_frame("after_timeout", 4'b0001, 32'h000000D4, 3, 0, 8'hD4);
`endif

    rand_test(200);
    req = 4'b0;
    tick;
    chk("rand", "drain_idle", 32'(busy), 32'(0));

    // Reset in the middle of a frame: no ack, pointer back to requester 0.
    req = 4'b0010;
    req_data = 32'h00005A00;
    tick;
    chk("rst_mid", "tx_start", 32'(tx_start), 32'(1));
    chk("rst_mid", "grant_id", 32'(grant_id), 32'(1));
    tick;
    tick;
    tick;
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_mid", "ack", 32'(ack), 32'(0));
    chk("rst_mid", "grant_id0", 32'(grant_id), 32'(0));
    chk("rst_mid", "busy", 32'(busy), 32'(0));
    chk("rst_mid", "tx_start0", 32'(tx_start), 32'(0));
    chk("rst_mid", "tx_data", 32'(tx_data), 32'(0));
    chk("rst_mid", "timeout_err", 32'(timeout_err), 32'(0));
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk("rst_mid", "no_ack", 32'(ack), 32'(0));
    m_last = 3;
    m_terr = 1'b0;
    reset_n = 1'b1;
    run_frame("rst_mid_next", 4'b1111, 32'h44332211, 4, 0, 8'h11);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
